// File: rtl/da2_req_arbiter.sv
// da2_req_arbiter: round-robin arbiter sharing one Pmod DA2 serial interface
// between two 12-bit sample requesters. Tracks each frame through the da2
// SYNC line, enforces an inter-frame gap and aborts hung transfers.
module da2_req_arbiter #(
   parameter int unsigned GAP_CYC     = 2,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a_valid,
   input  logic [11:0] req_a_val,
   output logic        req_a_ack,
   input  logic        req_b_valid,
   input  logic [11:0] req_b_val,
   output logic        req_b_ack,
   input  logic        dac_sync,
   output logic        dac_update,
   output logic [11:0] dac_val,
   output logic [1:0]  dac_sel,
   output logic        busy,
   output logic        err_timeout,
   input  logic        err_clr
);

   // One counter serves both the timeout watchdog and the gap timer; they
   // are never active in the same state.
   localparam int unsigned CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          last_b;
   logic          grant;
   logic          win_b;
   logic          to_hit;

   // Next-state logic: arbitration in IDLE, SYNC tracking, watchdog and gap timing
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      grant   = 1'b0;
      win_b   = 1'b0;
      to_hit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_a_valid || req_b_valid) begin
               grant   = 1'b1;
               // B wins when it is the only requester, or on contention when A went last
               win_b   = req_b_valid && (!req_a_valid || !last_b);
               state_n = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_n   = '0;
            state_n = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (!dac_sync) begin
               cnt_n   = '0;
               state_n = ST_WAIT_DONE;
            end else if (cnt == TO_LAST) begin
               cnt_n   = '0;
               to_hit  = 1'b1;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (dac_sync) begin
               cnt_n   = '0;
               state_n = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end else if (cnt == TO_LAST) begin
               cnt_n   = '0;
               to_hit  = 1'b1;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = ST_IDLE;
         end
      endcase
   end

   // State and shared counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Captured sample, channel select and round-robin pointer; change only on a grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dac_val <= '0;
         dac_sel <= 2'b00;
         last_b  <= 1'b1;
      end else if (grant) begin
         dac_val <= win_b ? req_b_val : req_a_val;
         dac_sel <= win_b ? 2'b10 : 2'b01;
         last_b  <= win_b;
      end
   end

   // Sticky timeout flag; a new timeout takes priority over a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_timeout <= 1'b0;
      end else if (to_hit) begin
         err_timeout <= 1'b1;
      end else if (err_clr) begin
         err_timeout <= 1'b0;
      end
   end

   // Strobes and status decoded from the state
   always_comb begin
      dac_update = (state == ST_ISSUE);
      req_a_ack  = dac_update && dac_sel[0];
      req_b_ack  = dac_update && dac_sel[1];
      busy       = (state != ST_IDLE);
   end

endmodule

// File: tb/tb_da2_req_arbiter.sv
// tb_da2_req_arbiter: two arbiters (GAP_CYC=2 and GAP_CYC=0) driven by random
// requesters and an emulated da2 SYNC line, checked against a timeline model.
module tb_da2_req_arbiter;

   localparam int TO = 16;
   localparam int NCYC = 3000;

   logic        clk = 1'b0;
   logic        rst;
   logic        va [2];
   logic        vb [2];
   logic [11:0] a_val [2];
   logic [11:0] b_val [2];
   logic        sync [2];
   logic        clr [2];
   logic        ack_a [2];
   logic        ack_b [2];
   logic        upd [2];
   logic [11:0] dval [2];
   logic [1:0]  dsel [2];
   logic        busy [2];
   logic        err [2];

   always #5 clk = ~clk;

   da2_req_arbiter #(.GAP_CYC(2), .TIMEOUT_CYC(TO)) dut_gap (
      .clk(clk), .rst(rst),
      .req_a_valid(va[0]), .req_a_val(a_val[0]), .req_a_ack(ack_a[0]),
      .req_b_valid(vb[0]), .req_b_val(b_val[0]), .req_b_ack(ack_b[0]),
      .dac_sync(sync[0]), .dac_update(upd[0]), .dac_val(dval[0]), .dac_sel(dsel[0]),
      .busy(busy[0]), .err_timeout(err[0]), .err_clr(clr[0])
   );

   da2_req_arbiter #(.GAP_CYC(0), .TIMEOUT_CYC(TO)) dut_nogap (
      .clk(clk), .rst(rst),
      .req_a_valid(va[1]), .req_a_val(a_val[1]), .req_a_ack(ack_a[1]),
      .req_b_valid(vb[1]), .req_b_val(b_val[1]), .req_b_ack(ack_b[1]),
      .dac_sync(sync[1]), .dac_update(upd[1]), .dac_val(dval[1]), .dac_sel(dsel[1]),
      .busy(busy[1]), .err_timeout(err[1]), .err_clr(clr[1])
   );

   // Timeline model: e counts clock edges since reset release. For each DUT:
   // G = edge of the last grant, F = first edge at which a new grant may occur,
   // T = edge at which a timeout fires (-1 if none), [lo,hi] = edges on which
   // the emulated da2 holds SYNC low.
   int          e;
   int          G [2];
   int          F [2];
   int          T [2];
   int          lo [2];
   int          hi [2];
   logic        last_b [2];
   logic        winb [2];
   logic        err_m [2];
   logic [11:0] m_val [2];
   logic [1:0]  m_sel [2];
   logic        drop_a [2];
   logic        drop_b [2];
   int          n_chk = 0;
   int          n_fail = 0;
   logic        did_rst = 1'b0;
   logic        post_rst = 1'b0;

   function automatic int gapv(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s[dut%0d] edge %0d: got %0h expected %0h", tag, i, e, obs, expv);
      end
   endtask

   task automatic model_reset(input int i);
      G[i]      = -100;
      F[i]      = e + 1;
      T[i]      = -1;
      lo[i]     = -1;
      hi[i]     = -1;
      last_b[i] = 1'b1;
      winb[i]   = 1'b0;
      err_m[i]  = 1'b0;
      m_val[i]  = '0;
      m_sel[i]  = 2'b00;
      drop_a[i] = 1'b0;
      drop_b[i] = 1'b0;
   endtask

   // Apply the rules at edge e using the inputs that were driven for this edge
   task automatic model_edge(input int i);
      int d;
      int len;
      int mode;
      if (e == T[i]) err_m[i] = 1'b1;
      else if (clr[i]) err_m[i] = 1'b0;
      if (e >= F[i] && (va[i] || vb[i])) begin
         winb[i]   = vb[i] && (!va[i] || !last_b[i]);
         last_b[i] = winb[i];
         G[i]      = e;
         m_val[i]  = winb[i] ? b_val[i] : a_val[i];
         m_sel[i]  = winb[i] ? 2'b10 : 2'b01;
         drop_a[i] = !winb[i];
         drop_b[i] = winb[i];
         mode = $urandom_range(0, 9);
         d    = $urandom_range(0, 3);
         if (mode == 0) begin
            // da2 never starts: watchdog fires TO edges after waiting begins
            lo[i] = -1; hi[i] = -1;
            T[i]  = e + 1 + TO;
            F[i]  = T[i] + 1;
         end else if (mode == 1) begin
            // da2 starts but SYNC stays low past the watchdog
            lo[i] = e + 2 + d;
            hi[i] = lo[i] + TO;
            T[i]  = lo[i] + TO;
            F[i]  = T[i] + 1;
         end else begin
            len   = $urandom_range(1, 8);
            lo[i] = e + 2 + d;
            hi[i] = lo[i] + len - 1;
            T[i]  = -1;
            F[i]  = hi[i] + 2 + gapv(i);
         end
      end
   endtask

   task automatic check_outputs(input int i);
      logic eu;
      eu = (e == G[i]);
      chk("dac_update", i, upd[i], eu);
      chk("req_a_ack", i, ack_a[i], eu && !winb[i]);
      chk("req_b_ack", i, ack_b[i], eu && winb[i]);
      chk("busy", i, busy[i], (G[i] <= e) && (e <= F[i] - 2));
      chk("dac_val", i, dval[i], m_val[i]);
      chk("dac_sel", i, dsel[i], m_sel[i]);
      chk("err_timeout", i, err[i], err_m[i]);
   endtask

   // Drive inputs for edge e+1: SYNC from the frame plan, random clears and requesters
   task automatic drive(input int i);
      int n;
      n = e + 1;
      sync[i] = !(lo[i] >= 0 && n >= lo[i] && n <= hi[i]);
      clr[i]  = ($urandom_range(0, 7) == 0);
      if (drop_a[i]) begin
         va[i] = 1'b0; drop_a[i] = 1'b0;
      end else if (!va[i] && $urandom_range(0, 1) == 1) begin
         va[i] = 1'b1; a_val[i] = 12'($urandom);
      end
      if (drop_b[i]) begin
         vb[i] = 1'b0; drop_b[i] = 1'b0;
      end else if (!vb[i] && $urandom_range(0, 1) == 1) begin
         vb[i] = 1'b1; b_val[i] = 12'($urandom);
      end
   endtask

   initial begin
      rst = 1'b1;
      e   = 0;
      for (int i = 0; i < 2; i++) begin
         va[i] = 1'b0; vb[i] = 1'b0; a_val[i] = '0; b_val[i] = '0;
         sync[i] = 1'b1; clr[i] = 1'b0;
         model_reset(i);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_outputs(i);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) drive(i);

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         e++;
         for (int i = 0; i < 2; i++) model_edge(i);
         @(negedge clk);
         for (int i = 0; i < 2; i++) check_outputs(i);
         if (post_rst) begin
            for (int i = 0; i < 2; i++) chk("rst_first_grant_a", i, ack_a[i], 1'b1);
            post_rst = 1'b0;
         end
         // Reset once while the GAP_CYC=2 arbiter is waiting for SYNC to return high
         if (!did_rst && c > 1000 && T[0] < 0 && lo[0] >= 0 && e >= lo[0] && e <= hi[0]) begin
            did_rst = 1'b1;
            chk("busy_before_rst", 0, busy[0], 1'b1);
            rst = 1'b1;
            #1;
            for (int i = 0; i < 2; i++) begin
               chk("rst_outputs", i, {ack_a[i], ack_b[i], upd[i], dval[i], dsel[i], busy[i], err[i]}, '0);
            end
            @(posedge clk);
            e++;
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 2; i++) begin
               model_reset(i);
               va[i] = 1'b1; a_val[i] = 12'($urandom);
               vb[i] = 1'b1; b_val[i] = 12'($urandom);
            end
            post_rst = 1'b1;
         end
         for (int i = 0; i < 2; i++) drive(i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
